// File: rtl/vga_vram_arbiter.sv
// Single-port VRAM arbiter: display reads always win, game-logic writes are queued
// in a small FIFO and drained in idle cycles. Also flags the end of visible video.
module vga_vram_arbiter #(
  parameter int AW    = 17,
  parameter int DW    = 12,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rstn,
  input  logic                       vs_en,
  input  logic                       disp_req,
  input  logic [AW-1:0]              disp_addr,
  output logic                       disp_valid,
  output logic [DW-1:0]              disp_data,
  input  logic                       wr_valid,
  input  logic [AW-1:0]              wr_addr,
  input  logic [DW-1:0]              wr_data,
  output logic                       wr_ready,
  output logic                       mem_en,
  output logic                       mem_we,
  output logic [AW-1:0]              mem_addr,
  output logic [DW-1:0]              mem_wdata,
  input  logic [DW-1:0]              mem_rdata,
  output logic [1:0]                 grant,
  output logic [$clog2(DEPTH):0]     buf_level,
  output logic                       frame_done
);

  localparam int PW = $clog2(DEPTH);
  localparam int LW = PW + 1;
  localparam logic [1:0] GNT_IDLE  = 2'd0;
  localparam logic [1:0] GNT_READ  = 2'd1;
  localparam logic [1:0] GNT_WRITE = 2'd2;

  logic [AW-1:0] fifo_addr_r [DEPTH];
  logic [DW-1:0] fifo_data_r [DEPTH];
  logic [PW-1:0] wr_ptr_r, rd_ptr_r;
  logic [LW-1:0] level_r;

  logic          full_s, empty_s, push_s, pop_s;
  logic [1:0]    grant_s, grant_r;
  logic          mem_en_s, mem_we_s, mem_en_r, mem_we_r;
  logic [AW-1:0] mem_addr_s, mem_addr_r;
  logic [DW-1:0] mem_wdata_s, mem_wdata_r;
  logic          rd_q_r, disp_valid_r, vs_q_r;

  // FIFO status and handshakes; a pop in this cycle never frees a slot for this cycle's push
  always_comb begin
    full_s  = (level_r == LW'(DEPTH));
    empty_s = (level_r == {LW{1'b0}});
    push_s  = wr_valid & ~full_s;
    pop_s   = ~disp_req & ~empty_s;
  end

  // Arbitration decision: display read, else FIFO drain, else idle with address/data held
  always_comb begin
    grant_s     = GNT_IDLE;
    mem_en_s    = 1'b0;
    mem_we_s    = 1'b0;
    mem_addr_s  = mem_addr_r;
    mem_wdata_s = mem_wdata_r;
    if (disp_req) begin
      grant_s    = GNT_READ;
      mem_en_s   = 1'b1;
      mem_addr_s = disp_addr;
    end else if (!empty_s) begin
      grant_s     = GNT_WRITE;
      mem_en_s    = 1'b1;
      mem_we_s    = 1'b1;
      mem_addr_s  = fifo_addr_r[rd_ptr_r];
      mem_wdata_s = fifo_data_r[rd_ptr_r];
    end else begin
      grant_s = GNT_IDLE;
    end
  end

  // FIFO storage; contents are don't-care until written, so no reset is needed
  always_ff @(posedge clk) begin
    if (push_s) begin
      fifo_addr_r[wr_ptr_r] <= wr_addr;
      fifo_data_r[wr_ptr_r] <= wr_data;
    end
  end

  // FIFO pointers and occupancy
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr_r <= {PW{1'b0}};
      rd_ptr_r <= {PW{1'b0}};
      level_r  <= {LW{1'b0}};
    end else begin
      if (push_s) wr_ptr_r <= wr_ptr_r + PW'(1);
      if (pop_s)  rd_ptr_r <= rd_ptr_r + PW'(1);
      case ({push_s, pop_s})
        2'b10:   level_r <= level_r + LW'(1);
        2'b01:   level_r <= level_r - LW'(1);
        default: level_r <= level_r;
      endcase
    end
  end

  // Registered VRAM port, read-valid pipeline and vs_en delay
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      mem_en_r     <= 1'b0;
      mem_we_r     <= 1'b0;
      mem_addr_r   <= {AW{1'b0}};
      mem_wdata_r  <= {DW{1'b0}};
      grant_r      <= GNT_IDLE;
      rd_q_r       <= 1'b0;
      disp_valid_r <= 1'b0;
      vs_q_r       <= 1'b0;
    end else begin
      mem_en_r     <= mem_en_s;
      mem_we_r     <= mem_we_s;
      mem_addr_r   <= mem_addr_s;
      mem_wdata_r  <= mem_wdata_s;
      grant_r      <= grant_s;
      rd_q_r       <= (grant_s == GNT_READ);
      disp_valid_r <= rd_q_r;
      vs_q_r       <= vs_en;
    end
  end

  // Read data is passed straight through so it lines up with the RAM's one-cycle latency
  assign disp_valid = disp_valid_r;
  assign disp_data  = disp_valid_r ? mem_rdata : {DW{1'b0}};
  assign wr_ready   = ~full_s;
  assign mem_en     = mem_en_r;
  assign mem_we     = mem_we_r;
  assign mem_addr   = mem_addr_r;
  assign mem_wdata  = mem_wdata_r;
  assign grant      = grant_r;
  assign buf_level  = level_r;
  assign frame_done = vs_q_r & ~vs_en;

endmodule

// File: tb/tb_vga_vram_arbiter.sv
// Directed self-checking bench for vga_vram_arbiter with a one-cycle-latency VRAM model.
module tb_vga_vram_arbiter;
  localparam int AW = 17;
  localparam int DW = 12;
  localparam int DEPTH = 4;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic          vs_en = 1'b0;
  logic          disp_req = 1'b0;
  logic [AW-1:0] disp_addr = '0;
  logic          disp_valid;
  logic [DW-1:0] disp_data;
  logic          wr_valid = 1'b0;
  logic [AW-1:0] wr_addr = '0;
  logic [DW-1:0] wr_data = '0;
  logic          wr_ready;
  logic          mem_en, mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata = '0;
  logic [1:0]    grant;
  logic [2:0]    buf_level;
  logic          frame_done;

  int errors = 0;
  int checks = 0;

  logic [DW-1:0] vram [0:(1<<AW)-1];

  vga_vram_arbiter #(.AW(AW), .DW(DW), .DEPTH(DEPTH)) dut (
    .clk(clk), .rstn(rstn), .vs_en(vs_en),
    .disp_req(disp_req), .disp_addr(disp_addr),
    .disp_valid(disp_valid), .disp_data(disp_data),
    .wr_valid(wr_valid), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ready(wr_ready),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .grant(grant), .buf_level(buf_level), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  // Synchronous single-port VRAM model
  always @(posedge clk) begin
    if (mem_en && mem_we) vram[mem_addr] <= mem_wdata;
    if (mem_en && !mem_we) mem_rdata <= vram[mem_addr];
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    repeat (3) cyc();
    rstn = 1'b1;
    cyc();
    checks++; if ({mem_en, mem_we} !== 2'b00) begin errors++; $display("FAIL reset_mem_en_we got=%b want=00", {mem_en, mem_we}); end
    checks++; if (mem_addr !== 17'h00000 || mem_wdata !== 12'h000) begin errors++; $display("FAIL reset_mem_addr_data got=%h/%h want=0/0", mem_addr, mem_wdata); end
    checks++; if (disp_valid !== 1'b0 || disp_data !== 12'h000) begin errors++; $display("FAIL reset_disp got=%b/%h want=0/000", disp_valid, disp_data); end
    checks++; if (grant !== 2'd0) begin errors++; $display("FAIL reset_grant got=%0d want=0", grant); end
    checks++; if (buf_level !== 3'd0) begin errors++; $display("FAIL reset_level got=%0d want=0", buf_level); end
    checks++; if (frame_done !== 1'b0) begin errors++; $display("FAIL reset_frame_done got=%b want=0", frame_done); end
    checks++; if (wr_ready !== 1'b1) begin errors++; $display("FAIL reset_wr_ready got=%b want=1", wr_ready); end
  endtask

  task automatic test_priority();
    bit we_seen = 1'b0;
    disp_req = 1'b1;
    for (int i = 0; i < 640; i++) begin
      disp_addr = 17'(i);
      wr_valid  = (i >= 10 && i < 13);
      wr_addr   = 17'(100 + i - 10);
      wr_data   = 12'(12'hA00 + i - 10);
      cyc();
      if (mem_we !== 1'b0) we_seen = 1'b1;
    end
    wr_valid = 1'b0;
    checks++; if (we_seen !== 1'b0) begin errors++; $display("FAIL prio_no_write got=%b want=0", we_seen); end
    checks++; if (buf_level !== 3'd3) begin errors++; $display("FAIL prio_level got=%0d want=3", buf_level); end
    checks++; if (grant !== 2'd1 || mem_addr !== 17'd639) begin errors++; $display("FAIL prio_read got=%0d/%h want=1/27f", grant, mem_addr); end
    disp_req = 1'b0;
    for (int k = 0; k < 3; k++) begin
      cyc();
      checks++;
      if (mem_we !== 1'b1 || mem_addr !== 17'(100 + k) || mem_wdata !== 12'(12'hA00 + k) || grant !== 2'd2 || buf_level !== 3'(2 - k)) begin
        errors++;
        $display("FAIL prio_drain%0d got we=%b a=%h d=%h g=%0d lvl=%0d want we=1 a=%h d=%h g=2 lvl=%0d",
                 k, mem_we, mem_addr, mem_wdata, grant, buf_level, 17'(100 + k), 12'(12'hA00 + k), 2 - k);
      end
    end
    cyc();
    checks++; if (mem_en !== 1'b0 || grant !== 2'd0 || mem_addr !== 17'd102) begin errors++; $display("FAIL prio_idle got en=%b g=%0d a=%h want 0/0/66", mem_en, grant, mem_addr); end
  endtask

  task automatic test_full();
    disp_req = 1'b1;
    disp_addr = 17'h00020;
    wr_valid = 1'b1;
    for (int j = 0; j < 4; j++) begin
      wr_addr = 17'(200 + j);
      wr_data = 12'(12'hB00 + j);
      cyc();
    end
    checks++; if (buf_level !== 3'd4 || wr_ready !== 1'b0) begin errors++; $display("FAIL full_level got=%0d/%b want=4/0", buf_level, wr_ready); end
    wr_addr = 17'd204;
    wr_data = 12'hB04;
    repeat (3) cyc();
    checks++; if (buf_level !== 3'd4 || wr_ready !== 1'b0) begin errors++; $display("FAIL full_hold got=%0d/%b want=4/0", buf_level, wr_ready); end
    disp_req = 1'b0;
    cyc();
    checks++; if (mem_we !== 1'b1 || mem_addr !== 17'd200 || buf_level !== 3'd3 || wr_ready !== 1'b1) begin
      errors++; $display("FAIL full_first_pop got we=%b a=%0d lvl=%0d rdy=%b want 1/200/3/1", mem_we, mem_addr, buf_level, wr_ready);
    end
    cyc();
    wr_valid = 1'b0;
    checks++; if (mem_addr !== 17'd201 || buf_level !== 3'd3) begin errors++; $display("FAIL full_push5 got a=%0d lvl=%0d want 201/3", mem_addr, buf_level); end
    for (int k = 2; k < 5; k++) begin
      cyc();
      checks++; if (mem_we !== 1'b1 || mem_addr !== 17'(200 + k) || mem_wdata !== 12'(12'hB00 + k)) begin
        errors++; $display("FAIL full_drain%0d got we=%b a=%0d d=%h want 1/%0d/%h", k, mem_we, mem_addr, mem_wdata, 200 + k, 12'(12'hB00 + k));
      end
    end
    cyc();
    checks++; if (mem_we !== 1'b0 || buf_level !== 3'd0) begin errors++; $display("FAIL full_empty got we=%b lvl=%0d want 0/0", mem_we, buf_level); end
  endtask

  task automatic test_latency();
    disp_req = 1'b1;
    disp_addr = 17'h00010;
    cyc();
    disp_req = 1'b0;
    checks++; if (mem_en !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 17'h00010 || disp_valid !== 1'b0) begin
      errors++; $display("FAIL lat_t1 got en=%b we=%b a=%h v=%b want 1/0/00010/0", mem_en, mem_we, mem_addr, disp_valid);
    end
    cyc();
    checks++; if (disp_valid !== 1'b1 || disp_data !== 12'hABC) begin errors++; $display("FAIL lat_t2 got v=%b d=%h want 1/abc", disp_valid, disp_data); end
    cyc();
    checks++; if (disp_valid !== 1'b0 || disp_data !== 12'h000) begin errors++; $display("FAIL lat_t3 got v=%b d=%h want 0/000", disp_valid, disp_data); end
  endtask

  task automatic test_push_pop_frame();
    disp_req = 1'b1;
    wr_valid = 1'b1;
    for (int j = 0; j < 2; j++) begin
      wr_addr = 17'(300 + j);
      wr_data = 12'(12'hC00 + j);
      cyc();
    end
    checks++; if (buf_level !== 3'd2) begin errors++; $display("FAIL pp_level got=%0d want=2", buf_level); end
    disp_req = 1'b0;
    wr_addr = 17'd302;
    wr_data = 12'hC02;
    cyc();
    wr_valid = 1'b0;
    checks++; if (buf_level !== 3'd2 || mem_we !== 1'b1 || mem_addr !== 17'd300) begin
      errors++; $display("FAIL pp_same_cycle got lvl=%0d we=%b a=%0d want 2/1/300", buf_level, mem_we, mem_addr);
    end
    for (int k = 1; k < 3; k++) begin
      cyc();
      checks++; if (mem_addr !== 17'(300 + k) || mem_wdata !== 12'(12'hC00 + k) || buf_level !== 3'(2 - k)) begin
        errors++; $display("FAIL pp_drain%0d got a=%0d d=%h lvl=%0d want %0d/%h/%0d", k, mem_addr, mem_wdata, buf_level, 300 + k, 12'(12'hC00 + k), 2 - k);
      end
    end
    vs_en = 1'b1;
    cyc();
    checks++; if (frame_done !== 1'b0) begin errors++; $display("FAIL fd_active got=%b want=0", frame_done); end
    vs_en = 1'b0;
    #1;
    checks++; if (frame_done !== 1'b1) begin errors++; $display("FAIL fd_pulse got=%b want=1", frame_done); end
    cyc();
    checks++; if (frame_done !== 1'b0) begin errors++; $display("FAIL fd_end got=%b want=0", frame_done); end
  endtask

  task automatic test_midop_reset();
    bit we_seen = 1'b0;
    disp_req = 1'b1;
    disp_addr = 17'h00030;
    wr_valid = 1'b1;
    for (int j = 0; j < 3; j++) begin
      wr_addr = 17'(400 + j);
      wr_data = 12'(12'hD00 + j);
      cyc();
    end
    wr_valid = 1'b0;
    checks++; if (buf_level !== 3'd3 || disp_valid !== 1'b1) begin errors++; $display("FAIL mr_before got lvl=%0d v=%b want 3/1", buf_level, disp_valid); end
    rstn = 1'b0;
    disp_req = 1'b0;
    #1;
    checks++; if (buf_level !== 3'd0 || disp_valid !== 1'b0) begin errors++; $display("FAIL mr_during got lvl=%0d v=%b want 0/0", buf_level, disp_valid); end
    cyc();
    rstn = 1'b1;
    for (int i = 0; i < 10; i++) begin
      cyc();
      if (mem_we !== 1'b0) we_seen = 1'b1;
    end
    checks++; if (we_seen !== 1'b0) begin errors++; $display("FAIL mr_no_write got=%b want=0", we_seen); end
    checks++; if (buf_level !== 3'd0 || disp_valid !== 1'b0) begin errors++; $display("FAIL mr_after got lvl=%0d v=%b want 0/0", buf_level, disp_valid); end
  endtask

  initial begin
    vram[17'h00010] = 12'hABC;
    test_reset();
    test_priority();
    test_full();
    test_latency();
    test_push_pop_frame();
    test_midop_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
